// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a variable-latency imem port and holds one
// fetched instruction for the IF/ID register. Redirects during an in-flight access are deferred.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic        if_valid
);

    typedef enum logic [0:0] {StRun, StSquash} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] saved_target_q, saved_target_d;

    logic        req_int;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign target = redirect_target & 32'hFFFF_FFFC;
    assign pc_inc = pc_q + 32'd4;

    // In SQUASH the stale access must still complete, so the request stays up.
    assign req_int = (state_q == StSquash) || !(buf_valid_q && stall);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        buf_valid_d    = buf_valid_q;
        buf_instr_d    = buf_instr_q;
        buf_pc4_d      = buf_pc4_q;
        saved_target_d = saved_target_q;

        unique case (state_q)
            StRun: begin
                if (redirect_valid) begin
                    buf_valid_d = 1'b0;
                    if (req_int && !imem_rvalid) begin
                        saved_target_d = target;
                        state_d        = StSquash;
                    end else begin
                        pc_d = target;
                    end
                end else if (req_int && imem_rvalid && (!buf_valid_q || !stall)) begin
                    buf_valid_d = 1'b1;
                    buf_instr_d = imem_rdata;
                    buf_pc4_d   = pc_inc;
                    pc_d        = pc_inc;
                end else if (!stall) begin
                    buf_valid_d = 1'b0;
                end
            end
            StSquash: begin
                buf_valid_d = 1'b0;
                if (redirect_valid) begin
                    saved_target_d = target;
                    if (imem_rvalid) begin
                        pc_d    = target;
                        state_d = StRun;
                    end
                end else if (imem_rvalid) begin
                    pc_d    = saved_target_q;
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StRun;
            pc_q           <= RESET_PC;
            buf_valid_q    <= 1'b0;
            buf_instr_q    <= 32'h0;
            buf_pc4_q      <= 32'h0;
            saved_target_q <= 32'h0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            buf_valid_q    <= buf_valid_d;
            buf_instr_q    <= buf_instr_d;
            buf_pc4_q      <= buf_pc4_d;
            saved_target_q <= saved_target_d;
        end
    end

    assign imem_req    = req_int && !reset;
    assign imem_addr   = pc_q;
    assign instruction = buf_valid_q ? buf_instr_q : 32'h0;
    assign pc_plus4    = buf_pc4_q;
    assign if_valid    = buf_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: two instances (normal and wrapping RESET_PC), each with an
// addr-as-data memory model; dut uses configurable wait states.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset, reset2;
    logic        stall, redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req, imem_rvalid, if_valid;
    logic [31:0] imem_addr, imem_rdata, instruction, pc_plus4;
    logic        req2, rvalid2, valid2;
    logic [31:0] addr2, rdata2, instr2, pc4_2;

    int unsigned lat;
    int unsigned cnt;
    int          checks;
    int          failures;

    if_fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instruction(instruction),
        .pc_plus4(pc_plus4), .if_valid(if_valid)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset2), .stall(1'b0), .redirect_valid(1'b0),
        .redirect_target(32'h0), .imem_req(req2), .imem_addr(addr2),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2), .instruction(instr2),
        .pc_plus4(pc4_2), .if_valid(valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: responds after `lat` wait cycles, data = address.
    assign imem_rvalid = imem_req && (cnt == lat);
    assign imem_rdata  = imem_addr;
    assign rvalid2     = req2;
    assign rdata2      = addr2;

    always @(posedge clk or posedge reset) begin
        if (reset) cnt <= 0;
        else if (imem_req && !imem_rvalid) cnt <= cnt + 1;
        else cnt <= 0;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        step();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
        checks++; if (instruction !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", instruction); end
        checks++; if (pc_plus4 !== 32'h0) begin failures++; $display("FAIL rst_pc4 got=%h exp=0", pc_plus4); end
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h0040_0000) begin failures++; $display("FAIL first_addr got=%h exp=00400000", imem_addr); end
    endtask

    task automatic test_stream();
        step();
        checks++; if (instruction !== 32'h0040_0000) begin failures++; $display("FAIL s0_instr got=%h exp=00400000", instruction); end
        checks++; if (pc_plus4 !== 32'h0040_0004) begin failures++; $display("FAIL s0_pc4 got=%h exp=00400004", pc_plus4); end
        checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL s0_valid got=%b exp=1", if_valid); end
        checks++; if (imem_addr !== 32'h0040_0004) begin failures++; $display("FAIL s0_addr got=%h exp=00400004", imem_addr); end
        step();
        checks++; if (instruction !== 32'h0040_0004) begin failures++; $display("FAIL s1_instr got=%h exp=00400004", instruction); end
        checks++; if (pc_plus4 !== 32'h0040_0008) begin failures++; $display("FAIL s1_pc4 got=%h exp=00400008", pc_plus4); end
        checks++; if (imem_addr !== 32'h0040_0008) begin failures++; $display("FAIL s1_addr got=%h exp=00400008", imem_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) step();
            else #1;
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req%0d got=%b exp=0", i, imem_req); end
            checks++; if (imem_addr !== 32'h0040_0008) begin failures++; $display("FAIL stall_addr%0d got=%h exp=00400008", i, imem_addr); end
            checks++; if (instruction !== 32'h0040_0004 || pc_plus4 !== 32'h0040_0008 || if_valid !== 1'b1) begin
                failures++; $display("FAIL stall_out%0d got=%h/%h/%b exp=00400004/00400008/1", i, instruction, pc_plus4, if_valid); end
        end
        stall = 1'b0;
        step();
        checks++; if (instruction !== 32'h0040_0008 || pc_plus4 !== 32'h0040_000C) begin
            failures++; $display("FAIL stall_resume got=%h/%h exp=00400008/0040000c", instruction, pc_plus4); end
        checks++; if (imem_addr !== 32'h0040_000C) begin failures++; $display("FAIL stall_next_addr got=%h exp=0040000c", imem_addr); end
    endtask

    task automatic test_redirect_zero_wait();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0040_0103;
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'h0040_0100) begin failures++; $display("FAIL rz_addr got=%h exp=00400100", imem_addr); end
        checks++; if (if_valid !== 1'b0 || instruction !== 32'h0) begin
            failures++; $display("FAIL rz_flush got=%b/%h exp=0/00000000", if_valid, instruction); end
        step();
        checks++; if (instruction !== 32'h0040_0100 || pc_plus4 !== 32'h0040_0104 || if_valid !== 1'b1) begin
            failures++; $display("FAIL rz_target got=%h/%h/%b exp=00400100/00400104/1", instruction, pc_plus4, if_valid); end
    endtask

    task automatic test_wait_redirect();
        lat = 3;
        // First wait cycle of the access to 0x00400104.
        redirect_valid  = 1'b1;
        redirect_target = 32'h0040_0200;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_addr !== 32'h0040_0104 || imem_req !== 1'b1 || if_valid !== 1'b0) begin
                failures++; $display("FAIL sq_hold%0d got=%h/%b/%b exp=00400104/1/0", i, imem_addr, imem_req, if_valid); end
            if (i != 2) step();
        end
        step();
        checks++; if (imem_addr !== 32'h0040_0200) begin failures++; $display("FAIL sq_target got=%h exp=00400200", imem_addr); end
        checks++; if (if_valid !== 1'b0 || instruction !== 32'h0) begin
            failures++; $display("FAIL sq_stale got=%b/%h exp=0/00000000", if_valid, instruction); end
        repeat (4) step();
        checks++; if (instruction !== 32'h0040_0200 || pc_plus4 !== 32'h0040_0204 || if_valid !== 1'b1) begin
            failures++; $display("FAIL sq_fetch got=%h/%h/%b exp=00400200/00400204/1", instruction, pc_plus4, if_valid); end
        redirect_valid  = 1'b1;
        redirect_target = 32'h0040_0250;
        step();
        redirect_target = 32'h0040_0300;
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'h0040_0204 || if_valid !== 1'b0) begin
            failures++; $display("FAIL sq2_hold got=%h/%b exp=00400204/0", imem_addr, if_valid); end
        repeat (2) step();
        checks++; if (imem_addr !== 32'h0040_0300) begin failures++; $display("FAIL sq2_target got=%h exp=00400300", imem_addr); end
        repeat (4) step();
        checks++; if (instruction !== 32'h0040_0300 || pc_plus4 !== 32'h0040_0304 || if_valid !== 1'b1) begin
            failures++; $display("FAIL sq2_fetch got=%h/%h/%b exp=00400300/00400304/1", instruction, pc_plus4, if_valid); end
    endtask

    task automatic test_async_reset();
        // Buffer holds 0x00400300 while the access to 0x00400304 waits.
        #1;
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            failures++; $display("FAIL arst_ctl got=%b/%b exp=0/0", imem_req, if_valid); end
        checks++; if (instruction !== 32'h0 || pc_plus4 !== 32'h0) begin
            failures++; $display("FAIL arst_data got=%h/%h exp=0/0", instruction, pc_plus4); end
        lat = 0;
        step();
        reset = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h0040_0000 || imem_req !== 1'b1) begin
            failures++; $display("FAIL arst_restart got=%h/%b exp=00400000/1", imem_addr, imem_req); end
        step();
        checks++; if (instruction !== 32'h0040_0000 || pc_plus4 !== 32'h0040_0004) begin
            failures++; $display("FAIL arst_fetch got=%h/%h exp=00400000/00400004", instruction, pc_plus4); end
    endtask

    task automatic test_wrap();
        step();
        checks++; if (req2 !== 1'b0) begin failures++; $display("FAIL wrap_rst_req got=%b exp=0", req2); end
        reset2 = 1'b0;
        #1;
        checks++; if (addr2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr0 got=%h exp=fffffffc", addr2); end
        step();
        checks++; if (instr2 !== 32'hFFFF_FFFC || pc4_2 !== 32'h0 || valid2 !== 1'b1) begin
            failures++; $display("FAIL wrap_out0 got=%h/%h/%b exp=fffffffc/00000000/1", instr2, pc4_2, valid2); end
        checks++; if (addr2 !== 32'h0) begin failures++; $display("FAIL wrap_addr1 got=%h exp=00000000", addr2); end
        step();
        checks++; if (instr2 !== 32'h0 || pc4_2 !== 32'h4) begin
            failures++; $display("FAIL wrap_out1 got=%h/%h exp=00000000/00000004", instr2, pc4_2); end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        lat             = 0;
        reset           = 1'b1;
        reset2          = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_zero_wait();
        test_wait_redirect();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
